// File: rtl/ctrl_pkg.sv
// Shared constants for the microcoded control unit: opcodes, micro-steps and
// the bit layout of the control word produced by the control ROM.
package ctrl_pkg;

  localparam int OPCODE_WIDTH = 4;
  localparam int STEP_WIDTH   = 3;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [STEP_WIDTH-1:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_e;

  // Bits 0..14 are bus strobes; END and HALT steer the step counter only.
  localparam int CW_PC_ENABLE = 0;
  localparam int CW_PC_JUMP   = 1;
  localparam int CW_PC_OUT    = 2;
  localparam int CW_MAR_IN    = 3;
  localparam int CW_RAM_OUT   = 4;
  localparam int CW_RAM_IN    = 5;
  localparam int CW_IR_IN     = 6;
  localparam int CW_IR_OUT    = 7;
  localparam int CW_A_IN      = 8;
  localparam int CW_A_OUT     = 9;
  localparam int CW_B_IN      = 10;
  localparam int CW_ALU_OUT   = 11;
  localparam int CW_ALU_SUB   = 12;
  localparam int CW_FLAGS_IN  = 13;
  localparam int CW_OUT_IN    = 14;
  localparam int CW_END       = 15;
  localparam int CW_HALT      = 16;
  localparam int CTRL_WIDTH   = 17;

endpackage

// File: rtl/control_sequencer_if.sv
// Control-strobe bundle between the sequencer (master) and the datapath
// (slave). No handshake: strobes are level signals valid for the current step.
interface control_sequencer_if;
  import ctrl_pkg::*;

  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    flag_carry;
  logic                    flag_zero;

  logic pc_enable;
  logic pc_jump;
  logic pc_out;
  logic mar_in;
  logic ram_out;
  logic ram_in;
  logic ir_in;
  logic ir_out;
  logic a_in;
  logic a_out;
  logic b_in;
  logic alu_out;
  logic alu_sub;
  logic flags_in;
  logic out_in;

  modport master (
    input  opcode, flag_carry, flag_zero,
    output pc_enable, pc_jump, pc_out, mar_in, ram_out, ram_in, ir_in, ir_out,
           a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in
  );

  modport slave (
    output opcode, flag_carry, flag_zero,
    input  pc_enable, pc_jump, pc_out, mar_in, ram_out, ram_in, ir_in, ir_out,
           a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in
  );

endinterface

// File: rtl/control_rom.sv
// Combinational microcode: (step, opcode, flags) -> control word.
// Undefined opcodes fall through to the NOP behaviour.
module control_rom
  import ctrl_pkg::*;
(
  input  step_e                   step_i,
  input  logic [OPCODE_WIDTH-1:0] opcode_i,
  input  logic                    flag_carry_i,
  input  logic                    flag_zero_i,
  output logic [CTRL_WIDTH-1:0]   cw_o
);

  always_comb begin
    cw_o = '0;
    case (step_i)
      T0: begin
        cw_o[CW_PC_OUT] = 1'b1;
        cw_o[CW_MAR_IN] = 1'b1;
      end
      T1: begin
        cw_o[CW_RAM_OUT]   = 1'b1;
        cw_o[CW_IR_IN]     = 1'b1;
        cw_o[CW_PC_ENABLE] = 1'b1;
      end
      T2: begin
        case (opcode_i)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw_o[CW_IR_OUT] = 1'b1;
            cw_o[CW_MAR_IN] = 1'b1;
          end
          OP_LDI: begin
            cw_o[CW_IR_OUT] = 1'b1;
            cw_o[CW_A_IN]   = 1'b1;
            cw_o[CW_END]    = 1'b1;
          end
          OP_JMP: begin
            cw_o[CW_IR_OUT]  = 1'b1;
            cw_o[CW_PC_JUMP] = 1'b1;
            cw_o[CW_END]     = 1'b1;
          end
          OP_JC: begin
            cw_o[CW_IR_OUT]  = flag_carry_i;
            cw_o[CW_PC_JUMP] = flag_carry_i;
            cw_o[CW_END]     = 1'b1;
          end
          OP_JZ: begin
            cw_o[CW_IR_OUT]  = flag_zero_i;
            cw_o[CW_PC_JUMP] = flag_zero_i;
            cw_o[CW_END]     = 1'b1;
          end
          OP_OUT: begin
            cw_o[CW_A_OUT]  = 1'b1;
            cw_o[CW_OUT_IN] = 1'b1;
            cw_o[CW_END]    = 1'b1;
          end
          OP_HLT: begin
            cw_o[CW_HALT] = 1'b1;
            cw_o[CW_END]  = 1'b1;
          end
          default: cw_o[CW_END] = 1'b1;
        endcase
      end
      T3: begin
        case (opcode_i)
          OP_LDA: begin
            cw_o[CW_RAM_OUT] = 1'b1;
            cw_o[CW_A_IN]    = 1'b1;
            cw_o[CW_END]     = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw_o[CW_RAM_OUT] = 1'b1;
            cw_o[CW_B_IN]    = 1'b1;
          end
          OP_STA: begin
            cw_o[CW_A_OUT]  = 1'b1;
            cw_o[CW_RAM_IN] = 1'b1;
            cw_o[CW_END]    = 1'b1;
          end
          default: cw_o[CW_END] = 1'b1;
        endcase
      end
      T4: begin
        if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
          cw_o[CW_ALU_OUT]  = 1'b1;
          cw_o[CW_A_IN]     = 1'b1;
          cw_o[CW_FLAGS_IN] = 1'b1;
          cw_o[CW_ALU_SUB]  = (opcode_i == OP_SUB);
        end
        cw_o[CW_END] = 1'b1;
      end
      default: cw_o[CW_END] = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Step counter and halt latch around the control ROM; strobes are gated off
// combinationally while in reset or halted.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int OPCODE_WIDTH = 4,
  parameter int STEP_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  control_sequencer_if.master   bus,
  output logic                  halted,
  output logic [STEP_WIDTH-1:0] step
);

  step_e                   step_q, step_d;
  logic                    halted_q, halted_d;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic [CTRL_WIDTH-1:0]   cw;
  logic                    gate;

  assign opcode = bus.opcode;

  control_rom u_rom (
    .step_i       (step_q),
    .opcode_i     (opcode),
    .flag_carry_i (bus.flag_carry),
    .flag_zero_i  (bus.flag_zero),
    .cw_o         (cw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  // Anything past T4 is unreachable, but is folded back to T0 for safety.
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (halted_q) begin
      step_d = T0;
    end else if (cw[CW_HALT]) begin
      halted_d = 1'b1;
      step_d   = T0;
    end else if (cw[CW_END] || step_q >= T4) begin
      step_d = T0;
    end else begin
      step_d = step_e'(step_q + 3'd1);
    end
  end

  assign gate   = rst_n & ~halted_q;
  assign halted = halted_q;
  assign step   = step_q;

  assign bus.pc_enable = gate & cw[CW_PC_ENABLE];
  assign bus.pc_jump   = gate & cw[CW_PC_JUMP];
  assign bus.pc_out    = gate & cw[CW_PC_OUT];
  assign bus.mar_in    = gate & cw[CW_MAR_IN];
  assign bus.ram_out   = gate & cw[CW_RAM_OUT];
  assign bus.ram_in    = gate & cw[CW_RAM_IN];
  assign bus.ir_in     = gate & cw[CW_IR_IN];
  assign bus.ir_out    = gate & cw[CW_IR_OUT];
  assign bus.a_in      = gate & cw[CW_A_IN];
  assign bus.a_out     = gate & cw[CW_A_OUT];
  assign bus.b_in      = gate & cw[CW_B_IN];
  assign bus.alu_out   = gate & cw[CW_ALU_OUT];
  assign bus.alu_sub   = gate & cw[CW_ALU_SUB];
  assign bus.flags_in  = gate & cw[CW_FLAGS_IN];
  assign bus.out_in    = gate & cw[CW_OUT_IN];

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a micro-program model builds the expected
// per-cycle strobes into a queue; a negedge monitor pops and compares.
module tb_control_sequencer;

  typedef struct packed {
    logic pc_enable, pc_jump, pc_out, mar_in, ram_out, ram_in, ir_in, ir_out;
    logic a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in;
  } strobes_t;

  logic       clk;
  logic       rst_n;
  logic       halted;
  logic [2:0] step;

  control_sequencer_if bus_if ();

  control_sequencer #(.OPCODE_WIDTH(4), .STEP_WIDTH(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus_if),
    .halted (halted),
    .step   (step)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state: entry = {halted, step, strobes}
  logic [18:0] exp_q[$];
  strobes_t    prog_q[$];
  int          n_compared = 0;
  int          n_mismatched = 0;

  function automatic strobes_t actual_strobes();
    strobes_t s;
    s.pc_enable = bus_if.pc_enable; s.pc_jump = bus_if.pc_jump;
    s.pc_out = bus_if.pc_out;       s.mar_in = bus_if.mar_in;
    s.ram_out = bus_if.ram_out;     s.ram_in = bus_if.ram_in;
    s.ir_in = bus_if.ir_in;         s.ir_out = bus_if.ir_out;
    s.a_in = bus_if.a_in;           s.a_out = bus_if.a_out;
    s.b_in = bus_if.b_in;           s.alu_out = bus_if.alu_out;
    s.alu_sub = bus_if.alu_sub;     s.flags_in = bus_if.flags_in;
    s.out_in = bus_if.out_in;
    return s;
  endfunction

  function automatic void check(string name, logic [18:0] act, logic [18:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s @%0t: got halted=%0b step=%0d strobes=%04h, want halted=%0b step=%0d strobes=%04h",
               name, $time, act[18], act[17:15], act[14:0], exp[18], exp[17:15], exp[14:0]);
    end
  endfunction

  // Reference model: the instruction's micro-program, one strobe set per step.
  task automatic build_prog(input logic [3:0] op, input logic c, input logic z);
    strobes_t w;
    prog_q.delete();
    w = '0; w.pc_out = 1; w.mar_in = 1; prog_q.push_back(w);
    w = '0; w.ram_out = 1; w.ir_in = 1; w.pc_enable = 1; prog_q.push_back(w);
    case (op)
      4'h1: begin
        w = '0; w.ir_out = 1; w.mar_in = 1; prog_q.push_back(w);
        w = '0; w.ram_out = 1; w.a_in = 1; prog_q.push_back(w);
      end
      4'h2, 4'h3: begin
        w = '0; w.ir_out = 1; w.mar_in = 1; prog_q.push_back(w);
        w = '0; w.ram_out = 1; w.b_in = 1; prog_q.push_back(w);
        w = '0; w.alu_out = 1; w.a_in = 1; w.flags_in = 1; w.alu_sub = (op == 4'h3);
        prog_q.push_back(w);
      end
      4'h4: begin
        w = '0; w.ir_out = 1; w.mar_in = 1; prog_q.push_back(w);
        w = '0; w.a_out = 1; w.ram_in = 1; prog_q.push_back(w);
      end
      4'h5: begin w = '0; w.ir_out = 1; w.a_in = 1; prog_q.push_back(w); end
      4'h6: begin w = '0; w.ir_out = 1; w.pc_jump = 1; prog_q.push_back(w); end
      4'h7: begin w = '0; w.ir_out = c; w.pc_jump = c; prog_q.push_back(w); end
      4'h8: begin w = '0; w.ir_out = z; w.pc_jump = z; prog_q.push_back(w); end
      4'hE: begin w = '0; w.a_out = 1; w.out_in = 1; prog_q.push_back(w); end
      default: begin w = '0; prog_q.push_back(w); end
    endcase
  endtask

  // driver tasks: entered and left at posedge + 1
  task automatic run_instr(input logic [3:0] op, input logic c, input logic z);
    bus_if.opcode = op; bus_if.flag_carry = c; bus_if.flag_zero = z;
    build_prog(op, c, z);
    for (int i = 0; i < prog_q.size(); i++)
      exp_q.push_back({1'b0, 3'(i), prog_q[i]});
    if (op == 4'hF)
      for (int i = 0; i < 20; i++) exp_q.push_back({1'b1, 3'd0, 15'd0});
    repeat (prog_q.size() + ((op == 4'hF) ? 20 : 0)) @(posedge clk);
    #1;
  endtask

  task automatic run_random(input int n);
    for (int k = 0; k < n; k++)
      run_instr(4'($urandom_range(0, 14)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic reset_cycles(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, 3'd0, 15'd0});
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // monitor: compare one expected entry per cycle, plus bus invariants
  always @(negedge clk) begin
    strobes_t s;
    logic [18:0] e;
    s = actual_strobes();
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cycle", {halted, step, s}, e);
    end
    if (rst_n) begin
      n_compared++;
      if ($countones({s.pc_out, s.ram_out, s.ir_out, s.a_out, s.alu_out}) > 1) begin
        n_mismatched++;
        $display("FAIL bus_onehot @%0t: drivers=%05b, required at most one",
                 $time, {s.pc_out, s.ram_out, s.ir_out, s.a_out, s.alu_out});
      end
      n_compared++;
      if (s.pc_enable && s.pc_jump) begin
        n_mismatched++;
        $display("FAIL pc_excl @%0t: pc_enable=1 pc_jump=1, required not both", $time);
      end
      n_compared++;
      if (step > 3'd4) begin
        n_mismatched++;
        $display("FAIL step_range @%0t: step=%0d, required <= 4", $time, step);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus_if.opcode = 4'h2; bus_if.flag_carry = 1'b0; bus_if.flag_zero = 1'b0;
    @(posedge clk); #1;
    reset_cycles(3);

    run_instr(4'h1, 1'b0, 1'b0);
    run_instr(4'h3, 1'b0, 1'b0);
    run_instr(4'h7, 1'b0, 1'b1);
    run_instr(4'h7, 1'b1, 1'b0);
    run_instr(4'h8, 1'b1, 1'b0);
    run_instr(4'h8, 1'b0, 1'b1);
    run_random(40);

    // asynchronous reset in the middle of ADD's T3
    bus_if.opcode = 4'h2;
    build_prog(4'h2, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 3'(i), prog_q[i]});
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midcycle_reset", {halted, step, actual_strobes()}, 19'd0);
    @(posedge clk); #1;
    reset_cycles(1);
    run_random(10);

    // halt, hold, then recover through reset
    run_instr(4'hF, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    reset_cycles(1);
    run_instr(4'h1, 1'b0, 1'b0);
    run_random(10);

    @(negedge clk); #1;
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
